frame_demux_dbuf: RTL and testbench
===================================

# frame_demux_dbuf

Parametrised successor to the serial-link word demultiplexer in `fpga_serial`. It collects `N_WORD` addressed words from the receiver into a shadow buffer. On a CRC-valid edge it copies the buffer one word per clock into a packed output bus. It adds CRC-error discard, frame-completeness checking, overrun detection and frame/error counters, and sits between the serial frame decoder and the control-loop register consumers.

## Interface
- `N_WORD`, 32: words per frame, legal 1..2^SEL_W.
- `DATA_W`, 16: word width.
- `SEL_W`, 8: width of `select`.
- `REQ_ALL`, 1: 1 = commit only if every index was written since the last commit or discard; 0 = no completeness check.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `select`  in  SEL_W  word index for `data_in`.
- `data_in`  in  DATA_W  received word.
- `data_strb`  in  1  write request; rising edge only.
- `crc_valid`  in  1  frame good; rising edge only.
- `crc_error`  in  1  frame bad; rising edge only.
- `data_out`  out  N_WORD*DATA_W  committed words; word k at `[k*DATA_W +: DATA_W]`.
- `receive_done`  out  1  level; high once a commit completes, low while copying.
- `busy`  out  1  high in COPY.
- `overrun`  out  1  sticky; cleared only by reset.
- `frame_cnt`  out  16  successful commits, wraps at 2^16.
- `err_cnt`  out  16  discarded frames, wraps at 2^16.

## Operation
- Edge detection: registered previous values of `data_strb`, `crc_valid` and `crc_error`. These registers sample every cycle, including during reset, so a level that is already high at reset release produces no event.
- Shadow buffer: `N_WORD` x `DATA_W`, RAM-inferable, not reset. `wr_mask` is `N_WORD` bits and is reset to 0.
- State IDLE:
  - Strobe edge with `select < N_WORD`: write the shadow entry and set its `wr_mask` bit.
  - Strobe edge with `select >= N_WORD`: ignored, no flag.
  - `crc_error` edge: clear `wr_mask`, increment `err_cnt`, stay in IDLE.
  - `crc_valid` edge with no error edge:
    - Complete (all mask bits set, or `REQ_ALL=0`): go to COPY, set `receive_done` low, set index to 0.
    - Incomplete: clear `wr_mask`, increment `err_cnt`, stay in IDLE.
  - `crc_error` and `crc_valid` edges in the same cycle: the error path wins.
  - Strobe edge together with a `crc_valid` edge: the write is applied and counted toward completeness, and its value is copied.
- State COPY:
  - Each cycle, read `shadow[idx]` and increment `idx`. The read data is registered into word `idx` of `data_out` on the following cycle.
  - After the last word: set `receive_done` high, increment `frame_cnt`, clear `wr_mask`, return to IDLE.
  - Any strobe, `crc_valid` or `crc_error` edge during COPY is ignored and sets `overrun`.
- Reset, including mid-COPY: go to IDLE and clear `data_out`, `receive_done`, `busy`, `overrun`, `frame_cnt`, `err_cnt`, `wr_mask` and `idx`. The shadow buffer keeps its contents.
- `data_out` words are never partially updated: each word is written with a complete shadow value.

## Timing
- T is the clock edge at which the `crc_valid` edge is detected.
  - At T: `busy` goes to 1 and `receive_done` goes to 0.
  - Word k of `data_out` updates at edge T+2+k.
  - At T+N_WORD+1: the last word, `receive_done`=1, `busy`=0 and the `frame_cnt` increment all take effect.
- Total commit latency is N_WORD+1 cycles. A new frame can be written starting from edge T+N_WORD+2.
- Shadow write: visible to a commit whose edge is detected in the same cycle or later.
- `err_cnt` and `frame_cnt` increment once per event; both wrap from 0xFFFF to 0x0000.
- Reset values: all outputs 0.

## Test plan
- Default parameters:
  - Write words `16'h1000+k` for k=0..31, then a `crc_valid` edge. Required: `data_out` word k = `16'h1000+k`, `receive_done` rises 33 cycles after T, `frame_cnt`=1.
  - Write 31 words (index 5 missing), then `crc_valid`. Required: `err_cnt`=1, `data_out` unchanged, `receive_done` stays 0, and a following full frame commits normally.
  - Full frame, then `crc_error` and `crc_valid` edges in the same cycle. Required: discarded, `err_cnt`=1, no COPY.
  - Strobe edge at T+3 during COPY. Required: `overrun`=1, shadow unchanged, copy completes; a second `crc_valid` edge during COPY is also ignored.
- `N_WORD=1`, `REQ_ALL=0`: `crc_valid` with no writes copies the stale shadow entry. Required: `receive_done` at T+2.
- Assert reset at T+10 mid-COPY. Required: next cycle all outputs are 0 and state is IDLE; a fresh full frame then commits correctly.

Source files
------------

// File: rtl/frame_demux_dbuf.sv
// Frame demultiplexer with a double buffer.
// Addressed words are collected into a shadow buffer. When a good-CRC edge arrives, the buffer
// is copied one word per clock into the packed output bus. Bad or incomplete frames are
// discarded and counted. Any event that arrives during the copy is flagged as an overrun.
module frame_demux_dbuf #(
  parameter int unsigned N_WORD  = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SEL_W   = 8,
  parameter bit          REQ_ALL = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SEL_W-1:0]           select,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_strb,
  input  logic                       crc_valid,
  input  logic                       crc_error,
  output logic [N_WORD*DATA_W-1:0]   data_out,
  output logic                       receive_done,
  output logic                       busy,
  output logic                       overrun,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                err_cnt
);

  localparam int unsigned AW = (N_WORD > 1) ? $clog2(N_WORD) : 1;
  localparam int unsigned IW = $clog2(N_WORD + 1);

  typedef enum logic [0:0] {StIdle, StCopy} state_e;

  state_e state_q, state_d;

  logic strb_q, valid_q, err_q;
  logic strb_edge, valid_edge, err_edge, any_edge;
  logic sel_ok, shadow_we, complete;
  logic start_copy, discard, finish, ovr_set;
  logic rd_en, rd_vld_q, last_word;
  logic [IW-1:0] idx_q, rd_idx_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] shadow_mem [N_WORD];
  logic [N_WORD-1:0] wr_mask_q, wr_set;
  logic [N_WORD*DATA_W-1:0] data_out_q;
  logic receive_done_q, overrun_q;
  logic [15:0] frame_cnt_q, err_cnt_q;

  // Edge detectors sample through reset so levels held across reset release create no event
  always_ff @(posedge clk) begin
    strb_q  <= data_strb;
    valid_q <= crc_valid;
    err_q   <= crc_error;
  end

  assign strb_edge  = data_strb & ~strb_q;
  assign valid_edge = crc_valid & ~valid_q;
  assign err_edge   = crc_error & ~err_q;
  assign any_edge   = strb_edge | valid_edge | err_edge;

  assign sel_ok    = (32'(select) < N_WORD);
  assign shadow_we = (state_q == StIdle) && strb_edge && sel_ok;

  // One-hot of the word being written this cycle, so a same-cycle commit counts it
  always_comb begin
    wr_set = '0;
    for (int unsigned k = 0; k < N_WORD; k++) begin
      wr_set[k] = shadow_we && (32'(select) == k);
    end
  end

  assign complete  = !REQ_ALL || (&(wr_mask_q | wr_set));
  assign rd_en     = (state_q == StCopy) && (32'(idx_q) < N_WORD);
  assign last_word = rd_vld_q && (32'(rd_idx_q) == N_WORD - 1);

  // Next-state and control decode; the error edge takes priority over a same-cycle valid edge
  always_comb begin
    state_d    = state_q;
    start_copy = 1'b0;
    discard    = 1'b0;
    finish     = 1'b0;
    ovr_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (err_edge) begin
          discard = 1'b1;
        end else if (valid_edge) begin
          if (complete) begin
            start_copy = 1'b1;
            state_d    = StCopy;
          end else begin
            discard = 1'b1;
          end
        end
      end
      StCopy: begin
        ovr_set = any_edge;
        if (last_word) begin
          finish  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Shadow buffer: not reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (shadow_we) shadow_mem[select[AW-1:0]] <= data_in;
    if (rd_en)     rd_data_q <= shadow_mem[idx_q[AW-1:0]];
  end

  // Copy pipeline, output bus, mask, flags and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q          <= '0;
      rd_idx_q       <= '0;
      rd_vld_q       <= 1'b0;
      data_out_q     <= '0;
      wr_mask_q      <= '0;
      receive_done_q <= 1'b0;
      overrun_q      <= 1'b0;
      frame_cnt_q    <= '0;
      err_cnt_q      <= '0;
    end else begin
      rd_vld_q <= rd_en;
      if (start_copy) begin
        idx_q <= '0;
      end else if (rd_en) begin
        idx_q    <= idx_q + 1'b1;
        rd_idx_q <= idx_q;
      end
      for (int unsigned k = 0; k < N_WORD; k++) begin
        if (rd_vld_q && (32'(rd_idx_q) == k)) data_out_q[k*DATA_W +: DATA_W] <= rd_data_q;
      end
      if (discard || finish) wr_mask_q <= '0;
      else if (shadow_we)    wr_mask_q <= wr_mask_q | wr_set;
      if (start_copy)  receive_done_q <= 1'b0;
      else if (finish) receive_done_q <= 1'b1;
      if (ovr_set) overrun_q <= 1'b1;
      if (finish)  frame_cnt_q <= frame_cnt_q + 16'd1;
      if (discard) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign data_out     = data_out_q;
  assign receive_done = receive_done_q;
  assign busy         = (state_q == StCopy);
  assign overrun      = overrun_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_frame_demux_dbuf.sv
// Bench for frame_demux_dbuf: a table of frames on the default build, plus hand-written
// sequences for overrun, mid-copy reset and a single-word build without the completeness check.
module tb_frame_demux_dbuf;

  localparam int unsigned NW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic reset, data_strb, crc_valid, crc_error;
  logic [SW-1:0] select;
  logic [DW-1:0] data_in;
  logic [NW*DW-1:0] data_out;
  logic receive_done, busy, overrun;
  logic [15:0] frame_cnt, err_cnt;

  frame_demux_dbuf #(.N_WORD(NW), .DATA_W(DW), .SEL_W(SW), .REQ_ALL(1'b1)) dut (
    .clk(clk), .reset(reset), .select(select), .data_in(data_in), .data_strb(data_strb),
    .crc_valid(crc_valid), .crc_error(crc_error), .data_out(data_out),
    .receive_done(receive_done), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  // Single-word build with no completeness check
  logic reset1, data_strb1, crc_valid1, crc_error1;
  logic [SW-1:0] select1;
  logic [DW-1:0] data_in1;
  logic [DW-1:0] data_out1;
  logic receive_done1, busy1, overrun1;
  logic [15:0] frame_cnt1, err_cnt1;

  frame_demux_dbuf #(.N_WORD(1), .DATA_W(DW), .SEL_W(SW), .REQ_ALL(1'b0)) dut1 (
    .clk(clk), .reset(reset1), .select(select1), .data_in(data_in1), .data_strb(data_strb1),
    .crc_valid(crc_valid1), .crc_error(crc_error1), .data_out(data_out1),
    .receive_done(receive_done1), .busy(busy1), .overrun(overrun1), .frame_cnt(frame_cnt1),
    .err_cnt(err_cnt1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] base;
    int          skip;      // index left unwritten, -1 for a full frame
    bit          use_valid;
    bit          use_err;
    bit          commit;
    logic [15:0] exp_err;
    logic [15:0] exp_frm;
  } vec_t;

  typedef struct {
    logic [NW*DW-1:0] bus;
    logic [15:0]      fcnt;
  } sb_t;

  vec_t vecs[6];
  sb_t  sb_q[$];
  logic [NW*DW-1:0] exp_bus;
  logic [15:0] exp_frm;
  logic exp_rd;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW*DW-1:0] frame_bus(input logic [15:0] base);
    logic [NW*DW-1:0] b;
    for (int k = 0; k < NW; k++) b[k*DW +: DW] = base + 16'(k);
    return b;
  endfunction

  task automatic write_word(input int sel, input logic [15:0] val);
    select    = SW'(sel);
    data_in   = val;
    data_strb = 1'b1;
    tick();
    data_strb = 1'b0;
    tick();
  endtask

  task automatic write_frame(input logic [15:0] base, input int skip);
    for (int k = 0; k < NW; k++) begin
      if (k != skip) write_word(k, base + 16'(k));
    end
  endtask

  // First tick lands on edge T+start; latency is reported relative to T
  task automatic wait_done(input int start, output int lat, output logic [15:0] w0);
    lat = -1;
    w0  = '0;
    for (int c = start; c <= start + 100; c++) begin
      tick();
      if (c == 2) w0 = data_out[15:0];
      if (receive_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic sb_check(input string name);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got empty scoreboard expected one entry", name);
    end else begin
      checks--;
      e = sb_q.pop_front();
      check({name, "_data"}, 512'(data_out), 512'(e.bus));
      check({name, "_fcnt"}, 512'(frame_cnt), 512'(e.fcnt));
    end
  endtask

  // Full frame followed by a lone valid edge; expected to commit
  task automatic do_commit(input string name, input logic [15:0] base);
    int lat;
    logic [15:0] w0;
    write_frame(base, -1);
    crc_valid = 1'b1;
    exp_bus   = frame_bus(base);
    exp_frm   = exp_frm + 16'd1;
    sb_q.push_back('{bus: exp_bus, fcnt: exp_frm});
    tick();
    crc_valid = 1'b0;
    check({name, "_busy_at_T"}, 512'(busy), 512'(1));
    check({name, "_done_low_at_T"}, 512'(receive_done), 512'(0));
    wait_done(1, lat, w0);
    check({name, "_latency"}, 512'(lat), 512'(NW + 1));
    check({name, "_word0_at_T2"}, 512'(w0), 512'(base));
    sb_check(name);
    check({name, "_busy_after"}, 512'(busy), 512'(0));
    exp_rd = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] w0;

    vecs[0] = '{16'h2000,  5, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vecs[1] = '{16'h1000, -1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};
    vecs[2] = '{16'h3000,  7, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1};
    vecs[3] = '{16'h4000, -1, 1'b1, 1'b1, 1'b0, 16'd3, 16'd1};
    vecs[4] = '{16'h5000, -1, 1'b0, 1'b1, 1'b0, 16'd4, 16'd1};
    vecs[5] = '{16'h6000, -1, 1'b1, 1'b0, 1'b1, 16'd4, 16'd2};

    reset = 1'b1; data_strb = 1'b0; crc_valid = 1'b0; crc_error = 1'b0;
    select = '0; data_in = '0;
    reset1 = 1'b1; data_strb1 = 1'b0; crc_valid1 = 1'b0; crc_error1 = 1'b0;
    select1 = '0; data_in1 = '0;
    exp_bus = '0; exp_frm = '0; exp_rd = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    reset1 = 1'b0;
    tick();

    check("rst_data_out", 512'(data_out), 512'(0));
    check("rst_receive_done", 512'(receive_done), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_overrun", 512'(overrun), 512'(0));
    check("rst_frame_cnt", 512'(frame_cnt), 512'(0));
    check("rst_err_cnt", 512'(err_cnt), 512'(0));

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].commit) begin
        do_commit($sformatf("vec%0d", v), vecs[v].base);
      end else begin
        write_frame(vecs[v].base, vecs[v].skip);
        crc_valid = vecs[v].use_valid;
        crc_error = vecs[v].use_err;
        tick();
        crc_valid = 1'b0;
        crc_error = 1'b0;
        check($sformatf("vec%0d_no_copy", v), 512'(busy), 512'(0));
        repeat (3) tick();
        check($sformatf("vec%0d_done", v), 512'(receive_done), 512'(exp_rd));
        check($sformatf("vec%0d_data_kept", v), 512'(data_out), 512'(exp_bus));
      end
      check($sformatf("vec%0d_err_cnt", v), 512'(err_cnt), 512'(vecs[v].exp_err));
      check($sformatf("vec%0d_frame_cnt", v), 512'(frame_cnt), 512'(vecs[v].exp_frm));
    end

    // Overrun: strobe at T+3 and a second valid edge at T+4, both during the copy
    write_frame(16'h7000, -1);
    crc_valid = 1'b1;
    exp_bus = frame_bus(16'h7000);
    exp_frm = exp_frm + 16'd1;
    sb_q.push_back('{bus: exp_bus, fcnt: exp_frm});
    tick();
    crc_valid = 1'b0;
    tick();
    tick();
    select = SW'(31); data_in = 16'hDEAD; data_strb = 1'b1;
    tick();
    data_strb = 1'b0;
    crc_valid = 1'b1;
    tick();
    crc_valid = 1'b0;
    check("ovr_flag_during_copy", 512'(overrun), 512'(1));
    wait_done(5, lat, w0);
    check("ovr_latency", 512'(lat), 512'(NW + 1));
    sb_check("ovr");
    check("ovr_err_cnt", 512'(err_cnt), 512'(4));
    tick();
    check("ovr_back_to_idle", 512'(busy), 512'(0));
    do_commit("after_ovr", 16'hA000);
    check("ovr_sticky", 512'(overrun), 512'(1));

    // Reset sampled at T+10 in the middle of a copy
    write_frame(16'h8000, -1);
    crc_valid = 1'b1;
    tick();
    crc_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("midrst_data_out", 512'(data_out), 512'(0));
    check("midrst_receive_done", 512'(receive_done), 512'(0));
    check("midrst_busy", 512'(busy), 512'(0));
    check("midrst_overrun", 512'(overrun), 512'(0));
    check("midrst_frame_cnt", 512'(frame_cnt), 512'(0));
    check("midrst_err_cnt", 512'(err_cnt), 512'(0));
    reset = 1'b0;
    tick();
    exp_frm = '0;
    exp_rd  = 1'b0;
    do_commit("post_rst", 16'h9000);
    check("post_rst_err_cnt", 512'(err_cnt), 512'(0));

    // Single-word build: one real frame, then a commit with no writes reuses the stale entry
    select1 = '0; data_in1 = 16'hABCD; data_strb1 = 1'b1;
    tick();
    data_strb1 = 1'b0;
    tick();
    crc_valid1 = 1'b1;
    tick();
    crc_valid1 = 1'b0;
    check("n1_busy_at_T", 512'(busy1), 512'(1));
    tick();
    check("n1_done_low_T1", 512'(receive_done1), 512'(0));
    tick();
    check("n1_done_T2", 512'(receive_done1), 512'(1));
    check("n1_data", 512'(data_out1), 512'(16'hABCD));
    check("n1_frame_cnt", 512'(frame_cnt1), 512'(1));
    select1 = SW'(1); data_in1 = 16'h1111; data_strb1 = 1'b1;
    tick();
    data_strb1 = 1'b0;
    tick();
    crc_valid1 = 1'b1;
    tick();
    crc_valid1 = 1'b0;
    tick();
    check("n1_stale_done_low_T1", 512'(receive_done1), 512'(0));
    tick();
    check("n1_stale_done_T2", 512'(receive_done1), 512'(1));
    check("n1_stale_data", 512'(data_out1), 512'(16'hABCD));
    check("n1_stale_frame_cnt", 512'(frame_cnt1), 512'(2));
    check("n1_err_cnt", 512'(err_cnt1), 512'(0));
    check("n1_overrun", 512'(overrun1), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
